// File: rtl/cas_square_dec_pkg.sv
// Shared tape timing constants and decoder state encoding.
// The square-wave encoder uses the same constants.
package cas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } cas_state_e;

  localparam int CAS_CW             = 16;
  localparam int CAS_TICKS_PER_STEP = 16;
  localparam int CAS_MIN_HI         = 6;
  localparam int CAS_THRESH         = 24;
  localparam int CAS_MAX_HI         = 48;
  localparam int CAS_MAX_PER        = 160;

  // Number of decoded cycles that make up one frame, including the start bit.
  function automatic logic [3:0] frame_bits(input logic ext);
    return ext ? 4'd9 : 4'd8;
  endfunction

endpackage

// File: rtl/cas_square_dec_if.sv
// Tape-side bundle: sampled level and controls in, decoded bytes and status out.
interface cas_square_dec_if;
  logic       tick;
  logic       enable;
  logic       extend;
  logic       tape_in;
  logic [7:0] dout;
  logic       valid;
  logic       err;
  logic       busy;

  modport master (
    output tick, enable, extend, tape_in,
    input  dout, valid, err, busy
  );

  modport slave (
    input  tick, enable, extend, tape_in,
    output dout, valid, err, busy
  );
endinterface

// File: rtl/cas_square_dec_edge.sv
// Two-flop synchronizer for the raw tape level plus a history flop for
// single-clock rise/fall pulses.
module cas_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
endmodule

// File: rtl/cas_square_dec.sv
// Cassette square-wave bit decoder: classifies each cycle by its high time,
// assembles MSB-first bytes and strobes them out with valid.
module cas_square_dec
  import cas_pkg::*;
#(
  parameter int CW      = CAS_CW,
  parameter int MIN_HI  = CAS_MIN_HI,
  parameter int THRESH  = CAS_THRESH,
  parameter int MAX_HI  = CAS_MAX_HI,
  parameter int MAX_PER = CAS_MAX_PER
) (
  input  logic              clk,
  input  logic              reset_n,
  cas_square_dec_if.slave   bus
);
  // State table:
  //   ST_IDLE | no frame in progress, waiting for a rising edge
  //   ST_HIGH | high half of a cycle, measuring high time
  //   ST_LOW  | low half of a cycle, waiting for next rise or timeout

  localparam logic [CW-1:0] MIN_HI_C  = CW'(MIN_HI);
  localparam logic [CW-1:0] THRESH_C  = CW'(THRESH);
  localparam logic [CW-1:0] MAX_HI_C  = CW'(MAX_HI);
  localparam logic [CW-1:0] MAX_PER_C = CW'(MAX_PER);

  logic            rise, fall;
  cas_state_e      state;
  logic [CW-1:0]   cnt;
  logic [3:0]      bitcnt;
  logic [7:0]      shreg;
  logic [7:0]      dout_q;
  logic            valid_q, err_q;
  logic            ext_q;
  logic            eff_ext, bit_val, accept_rise;
  logic [3:0]      bitcnt_nxt;
  logic [7:0]      shreg_nxt;

  cas_edge_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (bus.tape_in),
    .rise    (rise),
    .fall    (fall)
  );

  // extend only takes effect at a frame boundary; it is held for the rest of the byte.
  assign eff_ext     = (bitcnt == 4'd0) ? bus.extend : ext_q;
  assign bit_val     = (cnt < THRESH_C);
  assign bitcnt_nxt  = bitcnt + 4'd1;
  assign shreg_nxt   = {shreg[6:0], bit_val};
  assign accept_rise = rise && bus.enable && ((state == ST_IDLE) || (state == ST_LOW));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (accept_rise) begin
      cnt <= '0;
    end else if (bus.tick && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      bitcnt  <= 4'd0;
      shreg   <= 8'd0;
      ext_q   <= 1'b0;
      dout_q  <= 8'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (bitcnt == 4'd0) ext_q <= bus.extend;
      if (!bus.enable) begin
        state  <= ST_IDLE;
        bitcnt <= 4'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rise) state <= ST_HIGH;
          end
          ST_HIGH: begin
            // Short highs are glitches: stay here so the following rise is ignored too.
            if (fall && (cnt >= MIN_HI_C)) begin
              if (cnt > MAX_HI_C) begin
                err_q  <= 1'b1;
                bitcnt <= 4'd0;
                state  <= ST_IDLE;
              end else begin
                state <= ST_LOW;
                if (eff_ext && (bitcnt == 4'd0)) begin
                  if (!bit_val) bitcnt <= 4'd1;
                end else begin
                  shreg <= shreg_nxt;
                  if (bitcnt_nxt == frame_bits(eff_ext)) begin
                    dout_q  <= shreg_nxt;
                    valid_q <= 1'b1;
                    bitcnt  <= 4'd0;
                  end else begin
                    bitcnt <= bitcnt_nxt;
                  end
                end
              end
            end
          end
          ST_LOW: begin
            if (rise) begin
              state <= ST_HIGH;
            end else if (cnt >= MAX_PER_C) begin
              err_q  <= (bitcnt != 4'd0);
              bitcnt <= 4'd0;
              state  <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.dout  = dout_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;
  assign bus.busy  = (state != ST_IDLE);
endmodule
